hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine that owns the architectural Hi/Lo pair and responds to Execute-stage requests.
- Execute issues MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO through a Start/Op handshake, then reads Hi/Lo back for MFHI/MFLO.
- Replaces single-cycle Hi/Lo writes with an iterative datapath, plus a stall output toward the hazard unit.

Parameters:
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC cycle; legal values 1, 2, 4. Iteration count N = 32/BITS_PER_CYCLE.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous active-high reset.
- Start  input  1  request valid; sampled only when Busy=0.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- A  input  32  rs operand (multiplicand/dividend, or MTHI/MTLO data).
- B  input  32  rt operand (multiplier/divisor).
- ReadReq  input  1  Execute wants Hi or Lo this cycle (MFHI/MFLO).
- Busy  output  1  operation in flight.
- Done  output  1  one-cycle pulse in the cycle Hi/Lo take the new value.
- Stall  output  1  ReadReq & Busy, or Start & Busy; combinational.
- ReadHi  output  32  architectural Hi.
- ReadLo  output  32  architectural Lo.

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE. Reset mid-operation aborts it; no partial Hi/Lo write.
- FSM states: IDLE, CALC, FIX.
- IDLE, Start=1, Op in 0..5: latch |A| and |B| (magnitude for signed ops), result signs, and the Op. Busy=1 from the next cycle. Go to CALC with counter=N.
- IDLE, Start=1, Op 6/7: Hi or Lo <= A at the edge. Done=1 in the following cycle; Busy stays 0.
- CALC: retire BITS_PER_CYCLE bits per cycle. Multiply uses 64-bit shift-add; divide uses restoring shift-subtract. Decrement counter; at 0 go to FIX.
- FIX, one cycle: apply sign correction and write Hi/Lo, then go to IDLE. Done=1 and Busy=0 in the cycle after FIX.
- Total latency, Start edge to Done: N+2 cycles (34 at default).
- Multiply results:
  - MULT/MULTU: {Hi,Lo} = 64-bit product.
  - MADD: {Hi,Lo} += signed product.
  - MSUB: {Hi,Lo} -= signed product.
  - Accumulation wraps mod 2^64.
- Divide results: Lo = quotient, truncated toward zero; Hi = remainder, with the sign of the dividend.
- DIV 0x80000000 / -1: Lo=0x80000000, Hi=0.
- Divide by zero, DIV or DIVU: Lo=0xFFFFFFFF, Hi=A. Same N+2 latency; no exception.
- Start while Busy: ignored and Stall=1. Execute must hold Start/Op/A/B until Stall drops.
- ReadHi/ReadLo always show the committed registers. They change only on the Done-producing edge, never with intermediate values.
- ReadReq in the same cycle as Done: Done is registered, so the read sees the new values.

Optional Feature:
- HILO_EARLY_TERM_EN.
- Defined: multiply ops (0,1,4,5) leave CALC as soon as the remaining unshifted magnitude bits of B are all zero. Latency becomes ceil(msb_index(|B|)+1 / BITS_PER_CYCLE)+2; minimum 2 when |B|=0. Divides are unaffected.
- Undefined: every op takes the full N+2 cycles.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 34 cycles Done=1, Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for the 33 intervening cycles.
- MULT A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then MADD A=2, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF5. Then MSUB A=1, B=1 -> Lo=0xFFFFFFF4.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=7.
- MTHI A=0x12345678 -> ReadHi=0x12345678 next cycle with Done=1, Lo unchanged. ReadReq=1 during a DIV -> Stall=1 until the Done cycle.
- Start MULTU while Busy -> Stall=1 and the request is not accepted; Hi/Lo reflect only the first op. Assert Rst at CALC cycle 10 -> Hi=Lo=0, Busy=0, no Done pulse.
- With HILO_EARLY_TERM_EN, MULTU A=5, B=3 -> Done 4 cycles after Start, Lo=15. Without it -> 34 cycles. Repeat the first scenario at BITS_PER_CYCLE=4 -> latency 10.

Source files
------------

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage request/readback bundle for the Hi/Lo multiply/divide unit.
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadReq;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] ReadHi;
  logic [31:0] ReadLo;

  modport master (
    output Start, Op, A, B, ReadReq,
    input  Busy, Done, Stall, ReadHi, ReadLo
  );

  modport slave (
    input  Start, Op, A, B, ReadReq,
    output Busy, Done, Stall, ReadHi, ReadLo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural Hi/Lo pair.
// Optional HILO_EARLY_TERM_EN: multiplies finish once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic               Clk,
  input logic               Rst,
  hilo_muldiv_unit_if.slave bus
);
  localparam logic [5:0] N_ITER = 6'(32 / BITS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] x_q, x_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        busy;
  logic        is_div;
  logic        start_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc_c, x_c;
  logic [31:0] y_c;
  logic [32:0] r_c;
  logic [63:0] prod, mul_res;
  logic [31:0] quo_fix, rem_fix;

  assign busy       = (state_q != S_IDLE);
  assign is_div     = (op_q[2:1] == 2'b01);
  assign bus.Busy   = busy;
  assign bus.Done   = done_q;
  assign bus.Stall  = (bus.ReadReq | bus.Start) & busy;
  assign bus.ReadHi = hi_q;
  assign bus.ReadLo = lo_q;

  always_comb begin
    start_signed = (bus.Op == 3'd0) || (bus.Op == 3'd2) ||
                   (bus.Op == 3'd4) || (bus.Op == 3'd5);
    a_neg = start_signed & bus.A[31];
    b_neg = start_signed & bus.B[31];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;
  end

  // Divide keeps {remainder, quotient} in acc and the divisor in y;
  // multiply keeps the product in acc, shifted multiplicand in x, multiplier in y.
  always_comb begin
    acc_c = acc_q;
    x_c   = x_q;
    y_c   = y_q;
    r_c   = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        r_c          = {acc_c[63:32], acc_c[31]};
        acc_c[31:0]  = {acc_c[30:0], 1'b0};
        if (r_c >= {1'b0, y_c}) begin
          r_c      = r_c - {1'b0, y_c};
          acc_c[0] = 1'b1;
        end
        acc_c[63:32] = r_c[31:0];
      end else begin
        if (y_c[0]) acc_c = acc_c + x_c;
        x_c = {x_c[62:0], 1'b0};
        y_c = {1'b0, y_c[31:1]};
      end
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    case (op_q)
      3'd4:    mul_res = {hi_q, lo_q} + prod;
      3'd5:    mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
    // Divide by zero: restoring division already leaves remainder = |A|, only Lo needs forcing.
    quo_fix = (y_q == '0) ? '1 : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
    rem_fix = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Op == 3'd6) begin
            hi_d   = bus.A;
            done_d = 1'b1;
          end else if (bus.Op == 3'd7) begin
            lo_d   = bus.A;
            done_d = 1'b1;
          end else begin
            op_d    = bus.Op;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            x_d     = {32'd0, a_mag};
            y_d     = b_mag;
            acc_d   = (bus.Op[2:1] == 2'b01) ? {32'd0, a_mag} : '0;
            cnt_d   = N_ITER;
            state_d = S_CALC;
`ifdef HILO_EARLY_TERM_EN
            if ((bus.Op[2:1] != 2'b01) && (b_mag == '0)) state_d = S_FIX;
`endif
          end
        end
      end
      S_CALC: begin
        acc_d = acc_c;
        x_d   = x_c;
        y_d   = y_c;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_FIX;
`ifdef HILO_EARLY_TERM_EN
        if (!is_div && (y_c == '0)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: default-width instance plus a 4-bits-per-cycle instance.
module tb_hilo_muldiv_unit;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hilo_muldiv_unit_if bus ();
  hilo_muldiv_unit_if bus4 ();

  hilo_muldiv_unit dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  hilo_muldiv_unit #(.BITS_PER_CYCLE(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned issue;
    int unsigned lat;
    int unsigned busy;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc_n = 0;
  int unsigned busy_run = 0;
  logic [63:0] model_hl = '0;
  logic [63:0] h4 = '0;
  logic [31:0] sh_hi = '0;
  logic [31:0] sh_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return hl + sa * sb;
      3'd5: return hl - sa * sb;
      3'd6: return {a, hl[31:0]};
      default: return {hl[63:32], a};
    endcase
  endfunction

  function automatic int unsigned exp_lat(input logic [2:0] op, input logic [31:0] b,
                                          input int unsigned k);
    if (op >= 3'd6) return 1;
`ifdef HILO_EARLY_TERM_EN
    if (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5) begin
      logic [31:0] mag;
      int unsigned msb;
      mag = (op != 3'd1 && b[31]) ? -b : b;
      if (mag == 32'd0) return 2;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      return (msb + k) / k + 2;
    end
`endif
    return 32 / k + 2;
  endfunction

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model_hl = model(op, a, b, model_hl);
    e.hi    = model_hl[63:32];
    e.lo    = model_hl[31:0];
    e.issue = cyc_n;
    e.lat   = exp_lat(op, b, 1);
    e.busy  = (op >= 3'd6) ? 0 : e.lat - 1;
    exp_q.push_back(e);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      check_eq("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned k, lat;
    bit seen;
    h4   = model(op, a, b, h4);
    lat  = exp_lat(op, b, 4);
    k    = cyc_n;
    seen = 1'b0;
    bus4.Start = 1'b1;
    bus4.Op    = op;
    bus4.A     = a;
    bus4.B     = b;
    step();
    bus4.Start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus4.Done) begin
        check_eq("lat4", 64'(cyc_n - k), 64'(lat));
        check_eq("hi4", bus4.ReadHi, h4[63:32]);
        check_eq("lo4", bus4.ReadLo, h4[31:0]);
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) check_eq("timeout4", bus4.Done, 1);
  endtask

  // Pops one expectation per Done pulse; between pulses Hi/Lo must hold the committed values.
  always begin : mon
    exp_t e;
    @(posedge Clk);
    #1;
    cyc_n++;
    if (bus.Done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", bus.Done, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("hi", bus.ReadHi, e.hi);
        check_eq("lo", bus.ReadLo, e.lo);
        check_eq("latency", 64'(cyc_n - e.issue), 64'(e.lat));
        check_eq("busy_cycles", 64'(busy_run), 64'(e.busy));
        sh_hi = e.hi;
        sh_lo = e.lo;
      end
      busy_run = 0;
    end else begin
      check_eq("hold_hi", bus.ReadHi, sh_hi);
      check_eq("hold_lo", bus.ReadLo, sh_lo);
      if (bus.Busy) busy_run++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    logic [2:0]  op;
    logic [31:0] a, b;
    Rst = 1'b1;
    bus.Start = 1'b0;  bus.Op = '0;  bus.A = '0;  bus.B = '0;  bus.ReadReq = 1'b0;
    bus4.Start = 1'b0; bus4.Op = '0; bus4.A = '0; bus4.B = '0; bus4.ReadReq = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    Rst = 1'b0;
    step();
    check_eq("rst_hi", bus.ReadHi, 0);
    check_eq("rst_lo", bus.ReadLo, 0);
    check_eq("rst_busy", bus.Busy, 0);
    check_eq("rst_done", bus.Done, 0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(3'd0, -32'sd3, 32'd7);               wait_idle();
    issue(3'd4, 32'd2, 32'd5);                 wait_idle();
    issue(3'd5, 32'd1, 32'd1);                 wait_idle();
    issue(3'd2, -32'sd7, 32'd2);               wait_idle();
    issue(3'd3, 32'd7, 32'd0);                 wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(3'd2, -32'sd9, 32'd0);               wait_idle();
    issue(3'd6, 32'h1234_5678, 32'd0);         wait_idle();
    issue(3'd7, 32'hCAFE_F00D, 32'd0);         wait_idle();
    issue(3'd1, 32'd5, 32'd3);                 wait_idle();
    issue(3'd0, 32'd77, 32'd0);                wait_idle();

    // Read request held across a divide: stall exactly while busy.
    bus.ReadReq = 1'b1;
    k = cyc_n;
    issue(3'd2, 32'd100, -32'sd7);
    while (cyc_n <= k + 34) begin
      check_eq("stall_rd", bus.Stall, (cyc_n <= k + 33));
      if (cyc_n == k + 34) break;
      step();
    end
    bus.ReadReq = 1'b0;
    wait_idle();

    issue(3'd1, 32'h10, 32'h20);
    repeat (3) step();
    bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'h333; bus.B = 32'h444;
    #1;
    check_eq("stall_start", bus.Stall, 1);
    step();
    bus.Start = 1'b0;
    wait_idle();
    repeat (40) step();

    // Abort mid-CALC: committed state clears and no Done follows.
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (10) step();
    Rst = 1'b1;
    exp_q.delete();
    model_hl = '0;
    sh_hi = '0;
    sh_lo = '0;
    busy_run = 0;
    #1;
    check_eq("abort_hi", bus.ReadHi, 0);
    check_eq("abort_lo", bus.ReadLo, 0);
    check_eq("abort_busy", bus.Busy, 0);
    step();
    Rst = 1'b0;
    repeat (40) step();

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(op, a, b);
      wait_idle();
    end

    run4(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run4(3'd0, -32'sd3, 32'd7);
    run4(3'd2, -32'sd7, 32'd2);
    run4(3'd3, 32'd1000, 32'd7);
    run4(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run4(3'd5, 32'h0001_0000, 32'h0003_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
